segment_scan_capture: RTL
=========================

// Module: segment_scan_capture
// PURPOSE
//  Receive end of the multiplexed 7-segment display interface driven by the clock/calendar display path.
//  Samples the segment and digit-enable lines, waits for each digit to settle, and decodes each pattern back to a 4-bit code.
//  Assembles one code per digit into a frame and hands it off with valid/ready.
//  Used for on-chip loopback self-check of the displayed time and date.
// PARAMETERS
//  NUM_DIGITS     4   digit-enable lines scanned; frame width is 4*NUM_DIGITS
//  SETTLE_CYCLES  16  consecutive identical synced samples needed before a digit is accepted (>=2)
//  CNT_W          5   settle-counter width; must hold SETTLE_CYCLES
// PORTS
//  clock        in   1             single clock; every flop is on its rising edge
//  reset        in   1             asynchronous, active-high; clears all state
//  segment      in   7             active-high segments; bit0=a .. bit6=g; asynchronous to clock
//  bytee        in   NUM_DIGITS    active-high digit enables; bit0 = rightmost digit
//  frame_data   out  4*NUM_DIGITS  decoded codes; nibble i belongs to digit i
//  frame_valid  out  1             a frame is pending; held until it is accepted
//  frame_ready  in   1             consumer accepts the frame when frame_valid && frame_ready
//  overrun      out  1             one-cycle pulse when a pending frame is overwritten
//  decode_error out  1             sticky; set by an unknown pattern or a multi-hot enable; cleared only by reset
// BEHAVIOUR
//  Reset values: frame_data=0, frame_valid=0, overrun=0, decode_error=0; synchronizers, counter, capture mask and FSM all cleared.
//  Input sync: segment and bytee each pass through a 2-flop synchronizer. All logic below sees only the synced values.
//  Decode (combinational, on synced segment):
//   - 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F
//   - 00 -> 4'hF (blank)
//   - any other pattern -> 4'hE and sets decode_error
//  FSM states: IDLE, SETTLE, HOLD.
//   IDLE: no enable, or more than one enable active.
//    - Multi-hot enable sets decode_error and keeps the FSM in IDLE.
//    - Exactly one enable active -> SETTLE with cnt=1.
//   SETTLE: tracking the one active digit.
//    - Each cycle with the same {segment,bytee} as the previous cycle increments cnt.
//    - Any change: one-hot -> restart SETTLE with cnt=1; otherwise -> IDLE.
//    - When cnt reaches SETTLE_CYCLES: store the decoded code in nibble i of a shadow frame, set mask[i], go to HOLD.
//   HOLD: digit already stored.
//    - Wait for bytee to change, then handle the new value exactly as in IDLE.
//    - Segment-only changes are ignored, so each enable window stores at most one capture.
//  Latency: a digit is stored 2 + SETTLE_CYCLES cycles after its inputs settle.
//  Frame completion: all mask bits are set.
//   - On the cycle after the last store: frame_data <= shadow, frame_valid <= 1, mask <= 0.
//   - Recapturing a digit whose mask bit is already set overwrites that nibble; the frame still waits for the missing digits.
//  Handshake:
//   - frame_valid drops the cycle after acceptance.
//   - frame_data stays stable while frame_valid=1 and not accepted.
//   - Completion while valid=1 and no acceptance that cycle: the new frame replaces frame_data, valid stays 1, overrun pulses.
//   - Acceptance and completion in the same cycle: the new frame loads, valid stays 1, no overrun.
//  Reset mid-operation: the partial frame is discarded, outputs return to reset values, and the first frame after reset needs all digits.
// STRUCTURE
//  Shared package: 7-segment pattern constants (SEG_0..SEG_9, SEG_BLANK), codes CODE_BLANK=4'hF and CODE_ERR=4'hE, FSM state encoding.
//  Sub-module seg7_pattern_decode: pure combinational 7-bit pattern -> {code[3:0], err}.
//  Top level holds the synchronizers, FSM, settle counter, shadow frame/mask and output register.
// TESTING
//  1 Scan 4 digits; digit i shows {06,5B,4F,66} for 40 cycles each -> one frame_valid, frame_data=16'h4321, decode_error=0.
//  2 Hold digit0 on 5B for 10 cycles (< SETTLE_CYCLES), then cycle all 4 digits normally -> exactly one frame and no short-window capture; nibble0 is taken from its later full-length window.
//  3 Segment pattern 0x01 on digit2 -> nibble2=4'hE and decode_error=1, still set 1000 cycles later; pattern 0x00 -> nibble=4'hF with no error.
//  4 bytee=4'b0011 for 30 cycles -> decode_error=1 and no capture; then a normal scan -> one valid frame.
//  5 frame_ready=0 across two full scans of 1234 then 5678 -> overrun pulses once, frame_data=16'h8765 held until ready=1, valid low the next cycle.
//  6 Assert reset after 2 of 4 digits are captured, then release and scan 4 digits -> exactly one frame, containing only post-reset data.

Source files
------------

// File: rtl/segment_scan_capture_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns,
// special decode codes and the capture FSM state encoding.
package segment_scan_capture_pkg;

    // Active-high segment patterns, bit0=a .. bit6=g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Codes for patterns that are not decimal digits
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    // Capture FSM: waiting for a single enable, settling on one digit,
    // or holding after the digit of the current enable window was stored
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/segment_scan_capture_decode.sv
// Pure combinational 7-segment pattern decoder: returns the 4-bit code for a
// digit pattern, CODE_BLANK for an unlit digit and CODE_ERR plus err for
// anything else.
module seg7_pattern_decode
    import segment_scan_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       err
);

    // Map each known pattern to its code; unknown patterns flag an error
    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (pattern)
            SEG_0:     begin code = 4'h0;       err = 1'b0; end
            SEG_1:     begin code = 4'h1;       err = 1'b0; end
            SEG_2:     begin code = 4'h2;       err = 1'b0; end
            SEG_3:     begin code = 4'h3;       err = 1'b0; end
            SEG_4:     begin code = 4'h4;       err = 1'b0; end
            SEG_5:     begin code = 4'h5;       err = 1'b0; end
            SEG_6:     begin code = 4'h6;       err = 1'b0; end
            SEG_7:     begin code = 4'h7;       err = 1'b0; end
            SEG_8:     begin code = 4'h8;       err = 1'b0; end
            SEG_9:     begin code = 4'h9;       err = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
            default:   begin code = CODE_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/segment_scan_capture.sv
// Receive side of a multiplexed 7-segment display: synchronizes the segment
// and digit-enable lines, waits for each digit to settle, decodes it, and
// assembles one code per digit into a frame handed off with valid/ready.
module segment_scan_capture
    import segment_scan_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   bytee,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun,
    output logic                    decode_error
);

    // Two-flop synchronizers plus a one-cycle history of the synced values
    logic [6:0]            seg_s1;
    logic [6:0]            seg_s2;
    logic [6:0]            seg_p;
    logic [NUM_DIGITS-1:0] en_s1;
    logic [NUM_DIGITS-1:0] en_s2;
    logic [NUM_DIGITS-1:0] en_p;

    // FSM and settle counter
    scan_state_t           state;
    scan_state_t           state_next;
    logic [CNT_W-1:0]      cnt;

    // Shadow frame being assembled and the digits already stored in it
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   mask;
    logic                    frame_full;

    // Decoder results for the synced segment lines
    logic [3:0]            code;
    logic                  pat_err;

    // Conditions derived from the synced inputs
    logic                  one_hot;
    logic                  multi_hot;
    logic                  same;
    logic                  en_changed;
    logic                  settle_done;

    // FSM outputs
    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  store;
    logic                  multi_err;

    seg7_pattern_decode u_decode (
        .pattern (seg_s2),
        .code    (code),
        .err     (pat_err)
    );

    assign one_hot     = (en_s2 != '0) &&
                         ((en_s2 & (en_s2 - NUM_DIGITS'(1))) == '0);
    assign multi_hot   = (en_s2 != '0) && !one_hot;
    assign same        = (seg_s2 == seg_p) && (en_s2 == en_p);
    assign en_changed  = (en_s2 != en_p);
    // cnt counts identical samples seen so far; the store happens on the
    // edge where the count would reach SETTLE_CYCLES
    assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign frame_full  = &mask;

    // Synchronize the asynchronous display lines and keep the previous sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            seg_p  <= '0;
            en_s1  <= '0;
            en_s2  <= '0;
            en_p   <= '0;
        end else begin
            seg_s1 <= segment;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            en_s1  <= bytee;
            en_s2  <= en_s1;
            en_p   <= en_s2;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (same) begin
                    if (settle_done) begin
                        state_next = ST_HOLD;
                    end
                end else if (one_hot) begin
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Segment-only changes are ignored until the enable moves on
                if (en_changed) begin
                    state_next = one_hot ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: counter control, digit store and multi-hot error
    always_comb begin
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        store     = 1'b0;
        multi_err = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load  = one_hot;
                multi_err = multi_hot;
            end
            ST_SETTLE: begin
                if (same) begin
                    cnt_inc = !settle_done;
                    store   = settle_done;
                end else begin
                    cnt_load = one_hot;
                end
            end
            ST_HOLD: begin
                if (en_changed) begin
                    cnt_load  = one_hot;
                    multi_err = multi_hot;
                end
            end
            default: ;
        endcase
    end

    // Settle counter: restart at one on a new candidate, count stable samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_load) begin
            cnt <= CNT_W'(1);
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow frame: store the settled digit, clear the mask once handed off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            mask   <= '0;
        end else begin
            if (frame_full) begin
                mask <= '0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (store && en_s2[i]) begin
                    shadow[4*i +: 4] <= code;
                    mask[i]          <= 1'b1;
                end
            end
        end
    end

    // Output register and valid/ready handshake with overrun detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (frame_full) begin
                // A completed frame always loads; it only counts as an
                // overrun if the pending one is not being taken this cycle
                frame_data  <= shadow;
                frame_valid <= 1'b1;
                overrun     <= frame_valid && !frame_ready;
            end else begin
                overrun <= 1'b0;
                if (frame_valid && frame_ready) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

    // Sticky error flag for unknown patterns and multi-hot enables
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decode_error <= 1'b0;
        end else if (multi_err || (store && pat_err)) begin
            decode_error <= 1'b1;
        end
    end

endmodule
